// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing NR_PORTS scoreboard writeback ports among NR_REQ result producers.
// Optional `WB_ARB_STALL_CNT_EN adds a saturating stall_cnt_o counting cycles with refused requesters.
module wb_port_arbiter #(
    parameter int unsigned NR_REQ        = 4,
    parameter int unsigned NR_PORTS      = 3,
    parameter int unsigned TRANS_ID_BITS = 2,
    parameter int unsigned DATA_WIDTH    = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NR_REQ-1:0]                 req_valid_i,
    output logic [NR_REQ-1:0]                 req_ready_o,
    input  logic [NR_REQ*TRANS_ID_BITS-1:0]   req_trans_id_i,
    input  logic [NR_REQ*DATA_WIDTH-1:0]      req_result_i,
    input  logic [NR_REQ-1:0]                 req_ex_valid_i,
    input  logic [NR_REQ*DATA_WIDTH-1:0]      req_ex_cause_i,
    output logic [NR_PORTS-1:0]               wb_valid_o,
    output logic [NR_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [NR_PORTS*DATA_WIDTH-1:0]    wb_result_o,
    output logic [NR_PORTS-1:0]               wb_ex_valid_o,
    output logic [NR_PORTS*DATA_WIDTH-1:0]    wb_ex_cause_o
`ifdef WB_ARB_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt_o
`endif
);

    localparam int unsigned PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int unsigned PORT_IW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned GCNT_W  = $clog2(NR_PORTS + 1);
    localparam int unsigned SUM_W   = PTR_W + 1;

    logic [PTR_W-1:0]         rr_ptr_q;
    logic [PTR_W-1:0]         rr_ptr_d;
    logic [PTR_W-1:0]         last_idx;
    logic [PTR_W-1:0]         scan_idx;
    logic [SUM_W-1:0]         scan_sum;
    logic [GCNT_W-1:0]        n_grant;
    logic [NR_PORTS-1:0]      sel_vld;
    logic [PTR_W-1:0]         sel [NR_PORTS];

    logic [TRANS_ID_BITS-1:0] req_tid   [NR_REQ];
    logic [DATA_WIDTH-1:0]    req_res   [NR_REQ];
    logic [DATA_WIDTH-1:0]    req_cause [NR_REQ];

    logic [TRANS_ID_BITS-1:0] wb_tid_q   [NR_PORTS];
    logic [DATA_WIDTH-1:0]    wb_res_q   [NR_PORTS];
    logic [DATA_WIDTH-1:0]    wb_cause_q [NR_PORTS];

    // Flattened request payloads into per-requester views
    for (genvar i = 0; i < NR_REQ; i++) begin : g_unpack
        assign req_tid[i]   = req_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS];
        assign req_res[i]   = req_result_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign req_cause[i] = req_ex_cause_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan from rr_ptr; k-th valid requester lands on port k
    always_comb begin
        req_ready_o = '0;
        sel_vld     = '0;
        sel         = '{default: '0};
        n_grant     = '0;
        last_idx    = rr_ptr_q;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (scan_sum >= SUM_W'(NR_REQ)) begin
                scan_sum = scan_sum - SUM_W'(NR_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!flush_i && req_valid_i[scan_idx] && (n_grant < GCNT_W'(NR_PORTS))) begin
                req_ready_o[scan_idx]     = 1'b1;
                sel[PORT_IW'(n_grant)]     = scan_idx;
                sel_vld[PORT_IW'(n_grant)] = 1'b1;
                n_grant                    = n_grant + GCNT_W'(1);
                last_idx                   = scan_idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (sel_vld[0]) begin
            rr_ptr_d = (last_idx == PTR_W'(NR_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (flush_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Writeback registers are reloaded every cycle; idle ports carry all-zero payloads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o    <= '0;
            wb_ex_valid_o <= '0;
            wb_tid_q      <= '{default: '0};
            wb_res_q      <= '{default: '0};
            wb_cause_q    <= '{default: '0};
        end else begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (!flush_i && sel_vld[PORT_IW'(p)]) begin
                    wb_valid_o[PORT_IW'(p)]    <= 1'b1;
                    wb_ex_valid_o[PORT_IW'(p)] <= req_ex_valid_i[sel[PORT_IW'(p)]];
                    wb_tid_q[PORT_IW'(p)]      <= req_tid[sel[PORT_IW'(p)]];
                    wb_res_q[PORT_IW'(p)]      <= req_res[sel[PORT_IW'(p)]];
                    wb_cause_q[PORT_IW'(p)]    <= req_cause[sel[PORT_IW'(p)]];
                end else begin
                    wb_valid_o[PORT_IW'(p)]    <= 1'b0;
                    wb_ex_valid_o[PORT_IW'(p)] <= 1'b0;
                    wb_tid_q[PORT_IW'(p)]      <= '0;
                    wb_res_q[PORT_IW'(p)]      <= '0;
                    wb_cause_q[PORT_IW'(p)]    <= '0;
                end
            end
        end
    end

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_pack
        assign wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] = wb_tid_q[p];
        assign wb_result_o[p*DATA_WIDTH +: DATA_WIDTH]         = wb_res_q[p];
        assign wb_ex_cause_o[p*DATA_WIDTH +: DATA_WIDTH]       = wb_cause_q[p];
    end

`ifdef WB_ARB_STALL_CNT_EN
    logic refused_c;

    assign refused_c = !flush_i && (|(req_valid_i & ~req_ready_o));

    // Saturating count of cycles where some valid requester was turned away
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (refused_c && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (4 requesters, 3 writeback ports).
module tb_wb_port_arbiter;

    localparam int unsigned NR_REQ   = 4;
    localparam int unsigned NR_PORTS = 3;
    localparam int unsigned TID_W    = 2;
    localparam int unsigned DW       = 64;

    logic                       clk_i;
    logic                       rst_ni;
    logic                       flush_i;
    logic [NR_REQ-1:0]          req_valid_i;
    logic [NR_REQ-1:0]          req_ready_o;
    logic [NR_REQ*TID_W-1:0]    req_trans_id_i;
    logic [NR_REQ*DW-1:0]       req_result_i;
    logic [NR_REQ-1:0]          req_ex_valid_i;
    logic [NR_REQ*DW-1:0]       req_ex_cause_i;
    logic [NR_PORTS-1:0]        wb_valid_o;
    logic [NR_PORTS*TID_W-1:0]  wb_trans_id_o;
    logic [NR_PORTS*DW-1:0]     wb_result_o;
    logic [NR_PORTS-1:0]        wb_ex_valid_o;
    logic [NR_PORTS*DW-1:0]     wb_ex_cause_o;
`ifdef WB_ARB_STALL_CNT_EN
    logic [31:0]                stall_cnt_o;
`endif

    logic [TID_W-1:0] rq_tid   [NR_REQ];
    logic [DW-1:0]    rq_res   [NR_REQ];
    logic [DW-1:0]    rq_cause [NR_REQ];
    logic [TID_W-1:0] wb_tid   [NR_PORTS];
    logic [DW-1:0]    wb_res   [NR_PORTS];
    logic [DW-1:0]    wb_cause [NR_PORTS];

    int n_tests;
    int n_fail;

    wb_port_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_trans_id_i (req_trans_id_i),
        .req_result_i   (req_result_i),
        .req_ex_valid_i (req_ex_valid_i),
        .req_ex_cause_i (req_ex_cause_i),
        .wb_valid_o     (wb_valid_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_result_o    (wb_result_o),
        .wb_ex_valid_o  (wb_ex_valid_o),
        .wb_ex_cause_o  (wb_ex_cause_o)
`ifdef WB_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    for (genvar i = 0; i < NR_REQ; i++) begin : g_req
        assign req_trans_id_i[i*TID_W +: TID_W] = rq_tid[i];
        assign req_result_i[i*DW +: DW]         = rq_res[i];
        assign req_ex_cause_i[i*DW +: DW]       = rq_cause[i];
    end

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_wb
        assign wb_tid[p]   = wb_trans_id_o[p*TID_W +: TID_W];
        assign wb_res[p]   = wb_result_o[p*DW +: DW];
        assign wb_cause[p] = wb_ex_cause_o[p*DW +: DW];
    end

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             flush;
        logic [3:0]       valid;
        logic [3:0]       ex;
        logic [3:0]       exp_ready;
        logic [2:0]       exp_wbv;
        logic [2:0][1:0]  src;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic fl, input logic [3:0] v, input logic [3:0] ex,
                                input logic [3:0] rdy, input logic [2:0] wbv,
                                input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
        vec_t r;
        r.flush     = fl;
        r.valid     = v;
        r.ex        = ex;
        r.exp_ready = rdy;
        r.exp_wbv   = wbv;
        r.src       = {s2, s1, s0};
        return r;
    endfunction

    function automatic logic [TID_W-1:0] f_tid(input int n, input int i);
        return TID_W'(n + i + 1);
    endfunction

    function automatic logic [DW-1:0] f_res(input int n, input int i);
        return {32'(n), 32'hC0DE_0000 | 32'(i)};
    endfunction

    function automatic logic [DW-1:0] f_cause(input int n, input int i);
        return DW'(256 * n + i + 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_port(input string tag, input int p, input logic v, input logic [TID_W-1:0] tid,
                              input logic [DW-1:0] res, input logic exv, input logic [DW-1:0] cause);
        check($sformatf("%s p%0d valid", tag, p), 64'(wb_valid_o[2'(p)]), 64'(v));
        check($sformatf("%s p%0d tid", tag, p), 64'(wb_tid[2'(p)]), 64'(tid));
        check($sformatf("%s p%0d result", tag, p), wb_res[2'(p)], res);
        check($sformatf("%s p%0d ex_valid", tag, p), 64'(wb_ex_valid_o[2'(p)]), 64'(exv));
        check($sformatf("%s p%0d ex_cause", tag, p), wb_cause[2'(p)], cause);
    endtask

    task automatic idle_inputs();
        flush_i        = 1'b0;
        req_valid_i    = '0;
        req_ex_valid_i = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            rq_tid[2'(i)]   = '0;
            rq_res[2'(i)]   = '0;
            rq_cause[2'(i)] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic apply_vec(input int n);
        vec_t v;
        int   s;
        v = vecs[n];
        @(negedge clk_i);
        flush_i        = v.flush;
        req_valid_i    = v.valid;
        req_ex_valid_i = v.ex;
        for (int i = 0; i < NR_REQ; i++) begin
            rq_tid[2'(i)]   = f_tid(n, i);
            rq_res[2'(i)]   = f_res(n, i);
            rq_cause[2'(i)] = f_cause(n, i);
        end
        #1;
        check($sformatf("vec%0d ready", n), 64'(req_ready_o), 64'(v.exp_ready));
        @(posedge clk_i);
        #1;
        for (int p = 0; p < NR_PORTS; p++) begin
            s = int'(v.src[2'(p)]);
            if (v.exp_wbv[2'(p)]) begin
                check_port($sformatf("vec%0d", n), p, 1'b1, f_tid(n, s), f_res(n, s),
                           v.ex[2'(s)], f_cause(n, s));
            end else begin
                check_port($sformatf("vec%0d", n), p, 1'b0, '0, '0, 1'b0, '0);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_ni  = 1'b1;
        idle_inputs();

        // Asynchronous reset before any clock edge
        #1 rst_ni = 1'b0;
        #2;
        check("reset wb_valid", 64'(wb_valid_o), 64'h0);
        check("reset wb_ex_valid", 64'(wb_ex_valid_o), 64'h0);
        check("reset wb_result", wb_result_o[63:0], 64'h0);
        check("reset ready", 64'(req_ready_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        //         flush valid    ex       ready    wbv     src0   src1   src2
        vecs[0]  = mk(0, 4'b1111, 4'b0000, 4'b0111, 3'b111, 2'd0, 2'd1, 2'd2);
        vecs[1]  = mk(0, 4'b1111, 4'b0101, 4'b1011, 3'b111, 2'd3, 2'd0, 2'd1);
        vecs[2]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 2'd0, 2'd0, 2'd0);
        vecs[3]  = mk(0, 4'b0001, 4'b0001, 4'b0001, 3'b001, 2'd0, 2'd0, 2'd0);
        vecs[4]  = mk(0, 4'b1010, 4'b0010, 4'b1010, 3'b011, 2'd1, 2'd3, 2'd0);
        vecs[5]  = mk(0, 4'b1100, 4'b0000, 4'b1100, 3'b011, 2'd2, 2'd3, 2'd0);
        vecs[6]  = mk(1, 4'b0110, 4'b0000, 4'b0000, 3'b000, 2'd0, 2'd0, 2'd0);
        vecs[7]  = mk(0, 4'b1110, 4'b1000, 4'b1110, 3'b111, 2'd1, 2'd2, 2'd3);
        vecs[8]  = mk(0, 4'b0011, 4'b0000, 4'b0011, 3'b011, 2'd0, 2'd1, 2'd0);
        vecs[9]  = mk(1, 4'b1001, 4'b0000, 4'b0000, 3'b000, 2'd0, 2'd0, 2'd0);
        vecs[10] = mk(0, 4'b1111, 4'b0000, 4'b0111, 3'b111, 2'd0, 2'd1, 2'd2);
        vecs[11] = mk(0, 4'b1000, 4'b0000, 4'b1000, 3'b001, 2'd3, 2'd0, 2'd0);

        for (int n = 0; n < 12; n++) begin
            apply_vec(n);
        end

        // Mid-operation reset clears registered outputs without a clock edge
        check("pre-reset wb_valid", 64'(wb_valid_o), 64'h1);
        rst_ni = 1'b0;
        #1;
        check("async reset wb_valid", 64'(wb_valid_o), 64'h0);
        check("async reset wb_result", wb_result_o[63:0], 64'h0);
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b1;

        // Single request, then contention proves rr_ptr moved to 3
        @(negedge clk_i);
        req_valid_i   = 4'b0100;
        rq_tid[2'd2]  = 2'd1;
        rq_res[2'd2]  = 64'hDEAD;
        #1;
        check("single ready", 64'(req_ready_o), 64'h4);
        @(posedge clk_i);
        #1;
        check_port("single", 0, 1'b1, 2'd1, 64'hDEAD, 1'b0, 64'h0);
        check_port("single", 1, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk_i);
        req_valid_i  = 4'b1111;
        rq_tid[2'd3] = 2'd3;
        rq_res[2'd3] = 64'hBEEF;
        #1;
        check("after single ready", 64'(req_ready_o), 64'hB);
        @(posedge clk_i);
        #1;
        check("after single wb_valid", 64'(wb_valid_o), 64'h7);
        check_port("after single", 0, 1'b1, 2'd3, 64'hBEEF, 1'b0, 64'h0);

        // Exception pass-through, then outputs drop when nothing is granted
        @(negedge clk_i);
        idle_inputs();
        req_valid_i    = 4'b0010;
        req_ex_valid_i = 4'b0010;
        rq_tid[2'd1]   = 2'd2;
        rq_res[2'd1]   = 64'h55;
        rq_cause[2'd1] = 64'h2;
        @(posedge clk_i);
        #1;
        check_port("exc", 0, 1'b1, 2'd2, 64'h55, 1'b1, 64'h2);
        @(negedge clk_i);
        idle_inputs();
        @(posedge clk_i);
        #1;
        check("idle wb_valid", 64'(wb_valid_o), 64'h0);
        check("idle wb_ex_valid", 64'(wb_ex_valid_o), 64'h0);

        // Flush following a grant: prior result shows only during the flush cycle
        @(negedge clk_i);
        req_valid_i  = 4'b0001;
        rq_res[2'd0] = 64'h77;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i     = 1'b1;
        req_valid_i = 4'b1001;
        #1;
        check("flush ready", 64'(req_ready_o), 64'h0);
        check("flush-cycle wb_valid", 64'(wb_valid_o), 64'h1);
        @(posedge clk_i);
        #1;
        check("post-flush wb_valid", 64'(wb_valid_o), 64'h0);
        check("post-flush wb_result", wb_result_o[63:0], 64'h0);
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 4'b1111;
        #1;
        check("post-flush ready", 64'(req_ready_o), 64'h7);
        @(posedge clk_i);
        #1;

`ifdef WB_ARB_STALL_CNT_EN
        // Four valid requesters against three ports refuse one per cycle
        do_reset();
        check("stall reset", 64'(stall_cnt_o), 64'h0);
        @(negedge clk_i);
        req_valid_i = 4'b1111;
        repeat (5) @(posedge clk_i);
        #1;
        check("stall count", 64'(stall_cnt_o), 64'd5);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("stall flush hold", 64'(stall_cnt_o), 64'd5);
        idle_inputs();
`endif

        do_reset();
        check("final reset wb_valid", 64'(wb_valid_o), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
